// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file write-back path.
//   ADDR_WIDTH    : register address width
//   REG_DATA_W    : register data width
//   WB_FIFO_DEPTH : default number of buffered write-back entries
//   wb_req_t      : one write-back request {addr, data}
//   wb_src_e      : write-back source, used as the round-robin priority state
package regfile_pkg;

    localparam int unsigned ADDR_WIDTH    = 5;
    localparam int unsigned REG_DATA_W    = 32;
    localparam int unsigned WB_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO of write-back requests with per-slot valid bits so the
// hazard compare can see every pending destination register.
// Ports:
//   clk, ares      : clock, synchronous active-high reset
//   push, push_req : enqueue request (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   head           : request at the read pointer
//   empty, full    : occupancy flags
//   entry_vld      : slot holds a pending request
//   entry_addr     : destination register of each slot
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 ares,
    input  logic                                 push,
    input  wb_req_t                              push_req,
    input  logic                                 pop,
    output wb_req_t                              head,
    output logic                                 empty,
    output logic                                 full,
    output logic [DEPTH-1:0]                     entry_vld,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     entry_addr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (ares) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop_ok)  rptr <= rptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Push never targets the popped slot: that would need a full FIFO.
            if (pop_ok)  entry_vld[rptr] <= 1'b0;
            if (push_ok) entry_vld[wptr] <= 1'b1;
        end
    end

    // Storage needs no reset; entry_vld qualifies every slot.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_req;
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port. Round-robin
// arbitration between ALU and LSU, x0 writes dropped, one drain per cycle
// into registered wen/waddr/wdata, and pending-write hazard lookup.
// Optional macro REGFILE_WB_PERF_EN adds stall_cnt / drop_cnt counters.
// Ports:
//   clk, ares                       : clock, synchronous active-high reset
//   alu_valid/ready/addr/data       : ALU write-back request handshake
//   lsu_valid/ready/addr/data       : load write-back request handshake
//   wen, waddr, wdata               : registered register-file write port
//   chk_addr1/2, chk_hit1/2         : hazard query (hit is combinational)
//   busy                            : FIFO non-empty or write in progress
//   stall_cnt, drop_cnt             : perf counters (REGFILE_WB_PERF_EN only)
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  ares,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [REG_DATA_W-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [REG_DATA_W-1:0] lsu_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [REG_DATA_W-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_hit1,
    output logic                  chk_hit2,
    output logic                  busy
`ifdef REGFILE_WB_PERF_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    wb_src_e                             prio_q;
    wb_src_e                             prio_d;
    logic                                grant_alu;
    logic                                grant_lsu;
    logic                                xfer;
    logic                                push;
    wb_req_t                             sel_req;
    wb_req_t                             head;
    logic                                fifo_empty;
    logic                                fifo_full;
    logic [FIFO_DEPTH-1:0]               entry_vld;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;

    regfile_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .ares       (ares),
        .push       (push),
        .push_req   (sel_req),
        .pop        (!fifo_empty),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .entry_vld  (entry_vld),
        .entry_addr (entry_addr)
    );

    // Round-robin priority register.
    always_ff @(posedge clk) begin
        if (ares) prio_q <= SRC_ALU;
        else      prio_q <= prio_d;
    end

    // Arbitration, handshake and next priority. Full blocks acceptance even
    // when a pop happens in the same cycle.
    always_comb begin
        prio_d    = prio_q;
        grant_alu = alu_valid && (!lsu_valid || (prio_q == SRC_ALU));
        grant_lsu = lsu_valid && !grant_alu;
        alu_ready = grant_alu && !fifo_full && !ares;
        lsu_ready = grant_lsu && !fifo_full && !ares;
        xfer      = alu_ready || lsu_ready;
        sel_req   = '{addr: lsu_addr, data: lsu_data};
        if (grant_alu) sel_req = '{addr: alu_addr, data: alu_data};
        push      = xfer && (sel_req.addr != '0);
        if (xfer) prio_d = grant_alu ? SRC_LSU : SRC_ALU;
    end

    // Drain one entry per cycle into the write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (ares) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (!fifo_empty) begin
            wen   <= 1'b1;
            waddr <= head.addr;
            wdata <= head.data;
        end else begin
            wen   <= 1'b0;
        end
    end

    assign busy = !fifo_empty || wen;

    function automatic logic pending_hit(
        input logic [ADDR_WIDTH-1:0]                 a,
        input logic [FIFO_DEPTH-1:0]                 vld,
        input logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
        input logic                                  w,
        input logic [ADDR_WIDTH-1:0]                 wa
    );
        logic hit;
        hit = w && (wa == a);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (vld[i] && (addrs[i] == a)) hit = 1'b1;
        end
        return hit && (a != '0);
    endfunction

    // Hazard lookup against queued entries and the write in flight.
    always_comb begin
        chk_hit1 = pending_hit(chk_addr1, entry_vld, entry_addr, wen, waddr);
        chk_hit2 = pending_hit(chk_addr2, entry_vld, entry_addr, wen, waddr);
    end

`ifdef REGFILE_WB_PERF_EN
    // Saturating stall and x0-drop counters.
    always_ff @(posedge clk) begin
        if (ares) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if ((alu_valid || lsu_valid) && !xfer && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (xfer && (sel_req.addr == '0) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    // Perf counters compiled out; datapath unchanged.
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: drivers push expected writes,
// a negedge monitor pops and compares whenever wen is high.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    logic                  clk = 1'b0;
    logic                  ares;
    logic                  alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr, lsu_addr, waddr, chk_addr1, chk_addr2;
    logic [REG_DATA_W-1:0] alu_data, lsu_data, wdata;
    logic                  wen, chk_hit1, chk_hit2, busy;
`ifdef REGFILE_WB_PERF_EN
    logic [15:0]           stall_cnt, drop_cnt;
`endif

    regfile_wb_queue dut (
        .clk       (clk),
        .ares      (ares),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_hit1  (chk_hit1),
        .chk_hit2  (chk_hit2),
        .busy      (busy)
`ifdef REGFILE_WB_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int wen_seen = 0;
    int both_rdy = 0;
    wb_req_t exp_q[$];
    logic [REG_DATA_W-1:0] rf [32];
    logic                  rf_wr [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Register file model fed by the DUT write port.
    always @(posedge clk) begin
        if (wen === 1'b1) begin
            rf[waddr]    <= wdata;
            rf_wr[waddr] <= 1'b1;
        end
    end

    // Monitor: every write must match the oldest expected request.
    always @(negedge clk) begin
        if (alu_ready === 1'b1 && lsu_ready === 1'b1) both_rdy++;
        if (wen === 1'b1) begin
            wen_seen++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", waddr, wdata);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                check("wb_addr", 64'(waddr), 64'(e.addr));
                check("wb_data", 64'(wdata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic do_reset();
        ares = 1'b1;
        idle();
        tick();
        tick();
        ares = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && exp_q.size() == 0) done = 1;
            else tick();
        end
        check("drain_done", 64'(done), 64'd1);
        tick();
    endtask

    // Both sources valid every cycle; bench-side round-robin model starting at ALU.
    task automatic stream(input int n, input logic [4:0] aa, input logic [31:0] ad0,
                          input logic [4:0] la, input logic [31:0] ld0, input bit inc);
        bit alu_turn = 1;
        int ia = 0;
        int il = 0;
        for (int t = 0; t < n; t++) begin
            alu_valid = 1'b1; alu_addr = aa; alu_data = inc ? ad0 + 32'(ia) : ad0;
            lsu_valid = 1'b1; lsu_addr = la; lsu_data = inc ? ld0 + 32'(il) : ld0;
            @(negedge clk);
            check("rr_alu_ready", 64'(alu_ready), 64'(alu_turn));
            check("rr_lsu_ready", 64'(lsu_ready), 64'(!alu_turn));
            if (alu_turn) begin exp_q.push_back('{addr: aa, data: alu_data}); ia++; end
            else          begin exp_q.push_back('{addr: la, data: lsu_data}); il++; end
            alu_turn = !alu_turn;
            tick();
        end
        idle();
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 32; i++) begin rf[i] = '0; rf_wr[i] = 1'b0; end
        ares = 1'b1; idle();
        alu_addr = '0; alu_data = '0; lsu_addr = '0; lsu_data = '0;
        chk_addr1 = '0; chk_addr2 = '0;

        // Reset state, with requests held valid during reset.
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_addr = 5'd5; lsu_addr = 5'd6;
        tick();
        @(negedge clk);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        idle();
        tick();
        ares = 1'b0;

        // Single ALU write, latency accept k -> wen in k+1..k+2.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("single_alu_ready", 64'(alu_ready), 64'd1);
        exp_q.push_back('{addr: 5'd3, data: 32'hDEADBEEF});
        tick(); idle();
        @(negedge clk);
        check("single_wen_k", 64'(wen), 64'd0);
        check("single_busy_k", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        check("single_wen_k1", 64'(wen), 64'd1);
        check("single_waddr", 64'(waddr), 64'd3);
        check("single_wdata", 64'(wdata), 64'hDEADBEEF);
        tick();
        wait_drain();
        check("rf3", 64'(rf[3]), 64'hDEADBEEF);

        // Alternation ALU, LSU, ALU, LSU from reset.
        do_reset();
        stream(4, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0);
        wait_drain();

        // Continuous pressure: 10 requests -> 10 writes in order.
        do_reset();
        w0 = wen_seen;
        stream(10, 5'd8, 32'hA000_0000, 5'd9, 32'hB000_0000, 1'b1);
        wait_drain();
        check("stream_write_count", 64'(wen_seen - w0), 64'd10);

        // x0 request acknowledged but never written.
        do_reset();
        w0 = wen_seen;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234;
        @(negedge clk);
        check("x0_alu_ready", 64'(alu_ready), 64'd1);
        tick(); idle();
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("x0_no_write", 64'(wen_seen - w0), 64'd0);
        check("x0_busy", 64'(busy), 64'd0);
`ifdef REGFILE_WB_PERF_EN
        check("x0_drop_cnt", 64'(drop_cnt), 64'd1);
        check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        tick();

        // Hazard tracking for LSU write to r7.
        chk_addr1 = 5'd7; chk_addr2 = 5'd0;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h77;
        @(negedge clk);
        check("haz_lsu_ready", 64'(lsu_ready), 64'd1);
        check("haz_hit1_pre", 64'(chk_hit1), 64'd0);
        exp_q.push_back('{addr: 5'd7, data: 32'h77});
        tick(); idle();
        @(negedge clk);
        check("haz_hit1_queued", 64'(chk_hit1), 64'd1);
        check("haz_hit2_queued", 64'(chk_hit2), 64'd0);
        tick();
        @(negedge clk);
        check("haz_hit1_wen", 64'(chk_hit1), 64'd1);
        check("haz_hit2_wen", 64'(chk_hit2), 64'd0);
        tick();
        @(negedge clk);
        check("haz_hit1_done", 64'(chk_hit1), 64'd0);
        check("haz_hit2_done", 64'(chk_hit2), 64'd0);
        tick();

        // Reset with requests in flight: queued r11 and offered r12 are lost.
        chk_addr1 = 5'd11; chk_addr2 = 5'd12;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h10;
        @(negedge clk);
        check("inflight_ready0", 64'(alu_ready), 64'd1);
        exp_q.push_back('{addr: 5'd10, data: 32'h10});
        tick();
        alu_addr = 5'd11; alu_data = 32'h11;
        @(negedge clk);
        check("inflight_ready1", 64'(alu_ready), 64'd1);
        tick();
        alu_addr = 5'd12; alu_data = 32'h12; ares = 1'b1;
        @(negedge clk);
        check("inflight_ready_rst", 64'(alu_ready), 64'd0);
        tick();
        ares = 1'b0; idle();
        @(negedge clk);
        check("post_rst_wen", 64'(wen), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_hit1", 64'(chk_hit1), 64'd0);
        check("post_rst_hit2", 64'(chk_hit2), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("rf11_unwritten", 64'(rf_wr[11]), 64'd0);
        check("rf12_unwritten", 64'(rf_wr[12]), 64'd0);

        check("readys_exclusive", 64'(both_rdy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
